// File: rtl/ripple_sampler_pkg.sv
// Shared constants, FSM state type and modular-delta helper for the ripple counter sampler.
// Used by ripple_count_sampler and sync_filter.
package ripple_sampler_pkg;

  localparam int CNT_W_DEF      = 3;
  localparam int ACC_W_DEF      = 12;
  localparam int STABLE_CYC_DEF = 2;

  typedef enum logic [0:0] {
    INIT  = 1'b0,
    TRACK = 1'b1
  } sampler_state_e;

  // Forward distance from prev to cur on a counter that is width bits wide.
  function automatic logic [31:0] mod_delta(input logic [31:0] cur,
                                            input logic [31:0] prev,
                                            input int unsigned width);
    logic [31:0] mask;
    if (width >= 32'd32) begin
      mask = 32'hFFFF_FFFF;
    end else begin
      mask = (32'h0000_0001 << width) - 32'h0000_0001;
    end
    return (cur - prev) & mask;
  endfunction

endpackage

// File: rtl/ripple_count_sampler_if.sv
// Ripple counter input and sampled-result bus of ripple_count_sampler.
// With RIPPLE_SAMPLER_SAT_EN defined the bus also carries the sticky acc_sat flag.
interface ripple_count_sampler_if #(
  parameter int CNT_W = 3,
  parameter int ACC_W = 12
);

  logic [CNT_W-1:0] q_in;
  logic             en;
  logic             clr;
  logic             count_valid;
  logic [CNT_W-1:0] sample_out;
  logic [ACC_W-1:0] count_out;
  logic             wrap_pulse;
  logic             step_err;
`ifdef RIPPLE_SAMPLER_SAT_EN
  logic             acc_sat;
`endif

  // Control side: drives the raw counter and controls, observes results.
  modport master (
    output q_in,
    output en,
    output clr,
    input  count_valid,
    input  sample_out,
    input  count_out,
    input  wrap_pulse,
`ifdef RIPPLE_SAMPLER_SAT_EN
    input  acc_sat,
`endif
    input  step_err
  );

  // Sampler side.
  modport slave (
    input  q_in,
    input  en,
    input  clr,
    output count_valid,
    output sample_out,
    output count_out,
    output wrap_pulse,
`ifdef RIPPLE_SAMPLER_SAT_EN
    output acc_sat,
`endif
    output step_err
  );

endinterface

// File: rtl/ripple_count_sampler_sync_filter.sv
// Two-flop synchronizer per bit followed by a stability filter; raises accept for one
// cycle when a new value has been seen STABLE_CYC consecutive samples in a row.
module sync_filter
  import ripple_sampler_pkg::*;
#(
  parameter int CNT_W      = CNT_W_DEF,
  parameter int STABLE_CYC = STABLE_CYC_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CNT_W-1:0] raw,
  output logic [CNT_W-1:0] value,
  output logic             accept
);

  localparam int             CW       = $clog2(STABLE_CYC + 1);
  localparam logic [CW-1:0]  STABLE_C = CW'(STABLE_CYC);
  localparam logic [CW-1:0]  ONE_C    = CW'(1);

  logic [CNT_W-1:0] s1_r;
  logic [CNT_W-1:0] s2_r;
  logic [CNT_W-1:0] prev_r;
  logic [CNT_W-1:0] last_acc_r;
  logic [CW-1:0]    cnt_r;
  logic [1:0]       fill_r;
  logic             have_acc_r;

  logic             fill_done_s;
  logic             changed_s;
  logic             reach_s;
  logic             accept_s;
  logic [CW-1:0]    cnt_nxt_s;

  // Filter decision; fill_r keeps reset contents of the sync flops from counting as a sample.
  always_comb begin
    cnt_nxt_s   = cnt_r;
    reach_s     = 1'b0;
    accept_s    = 1'b0;
    fill_done_s = fill_r[1];
    changed_s   = (cnt_r == {CW{1'b0}}) || (s2_r != prev_r);
    if (!fill_done_s) begin
      cnt_nxt_s = cnt_r;
    end else if (changed_s) begin
      cnt_nxt_s = ONE_C;
    end else if (cnt_r == STABLE_C) begin
      cnt_nxt_s = cnt_r;
    end else begin
      cnt_nxt_s = cnt_r + ONE_C;
    end
    if (fill_done_s && (cnt_nxt_s == STABLE_C) && (changed_s || (cnt_r != STABLE_C))) begin
      reach_s = 1'b1;
    end else begin
      reach_s = 1'b0;
    end
    if (reach_s && (!have_acc_r || (s2_r != last_acc_r))) begin
      accept_s = 1'b1;
    end else begin
      accept_s = 1'b0;
    end
  end

  // Synchronizer, filter counter and last-accepted value.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_r       <= {CNT_W{1'b0}};
      s2_r       <= {CNT_W{1'b0}};
      prev_r     <= {CNT_W{1'b0}};
      last_acc_r <= {CNT_W{1'b0}};
      cnt_r      <= {CW{1'b0}};
      fill_r     <= 2'b00;
      have_acc_r <= 1'b0;
    end else begin
      s1_r   <= raw;
      s2_r   <= s1_r;
      fill_r <= {fill_r[0], 1'b1};
      cnt_r  <= cnt_nxt_s;
      if (fill_done_s) begin
        prev_r <= s2_r;
      end
      if (accept_s) begin
        last_acc_r <= s2_r;
        have_acc_r <= 1'b1;
      end
    end
  end

  assign value  = s2_r;
  assign accept = accept_s;

endmodule

// File: rtl/ripple_count_sampler.sv
// Samples a 3-bit ripple up-counter, accumulates counted steps and flags wraps/missed steps.
// Optional macro RIPPLE_SAMPLER_SAT_EN: saturating total plus sticky acc_sat output.
module ripple_count_sampler
  import ripple_sampler_pkg::*;
#(
  parameter int CNT_W      = CNT_W_DEF,
  parameter int ACC_W      = ACC_W_DEF,
  parameter int STABLE_CYC = STABLE_CYC_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  ripple_count_sampler_if.slave bus
);

  localparam logic [0:0] ST_INIT  = INIT;
  localparam logic [0:0] ST_TRACK = TRACK;

  logic [CNT_W-1:0] value_s;
  logic             accept_s;

  logic [0:0]       state_r;
  logic             valid_r;
  logic [CNT_W-1:0] sample_r;
  logic [ACC_W-1:0] count_r;
  logic             wrap_r;
  logic             err_r;

  logic [0:0]       state_nxt_s;
  logic             valid_nxt_s;
  logic [CNT_W-1:0] sample_nxt_s;
  logic [ACC_W-1:0] count_acc_s;
  logic             err_acc_s;
  logic             wrap_nxt_s;
  logic [CNT_W-1:0] delta_s;
  logic [ACC_W:0]   sum_s;
  logic [ACC_W-1:0] add_s;
  logic             clip_s;
`ifdef RIPPLE_SAMPLER_SAT_EN
  logic             sat_r;
  logic             sat_acc_s;
`endif

  sync_filter #(
    .CNT_W      (CNT_W),
    .STABLE_CYC (STABLE_CYC)
  ) u_filter (
    .clk    (clk),
    .rst    (rst),
    .raw    (bus.q_in),
    .value  (value_s),
    .accept (accept_s)
  );

  // Step arithmetic; delta is taken CNT_W wide so 7->0 counts as one step.
  always_comb begin
    delta_s = CNT_W'(mod_delta(32'(value_s), 32'(sample_r), CNT_W));
    sum_s   = {1'b0, count_r} + (ACC_W+1)'(delta_s);
`ifdef RIPPLE_SAMPLER_SAT_EN
    if (sum_s[ACC_W]) begin
      add_s  = {ACC_W{1'b1}};
      clip_s = 1'b1;
    end else begin
      add_s  = sum_s[ACC_W-1:0];
      clip_s = 1'b0;
    end
`else
    add_s  = sum_s[ACC_W-1:0];
    clip_s = 1'b0;
`endif
  end

  // FSM and accumulator next state for an accepted value (clr applied at the register).
  always_comb begin
    state_nxt_s  = state_r;
    valid_nxt_s  = valid_r;
    sample_nxt_s = sample_r;
    count_acc_s  = count_r;
    err_acc_s    = err_r;
    wrap_nxt_s   = 1'b0;
`ifdef RIPPLE_SAMPLER_SAT_EN
    sat_acc_s    = sat_r;
`endif
    if (accept_s) begin
      case (state_r)
        ST_INIT: begin
          sample_nxt_s = value_s;
          valid_nxt_s  = 1'b1;
          state_nxt_s  = ST_TRACK;
        end
        ST_TRACK: begin
          sample_nxt_s = value_s;
          wrap_nxt_s   = (value_s < sample_r);
          if (bus.en) begin
            count_acc_s = add_s;
`ifdef RIPPLE_SAMPLER_SAT_EN
            sat_acc_s   = sat_r | clip_s;
`endif
          end else begin
            count_acc_s = count_r;
          end
          if (delta_s > CNT_W'(1)) begin
            err_acc_s = 1'b1;
          end else begin
            err_acc_s = err_r;
          end
        end
        default: begin
          state_nxt_s = ST_INIT;
        end
      endcase
    end else begin
      state_nxt_s = state_r;
    end
  end

  // Output registers; rst outranks clr, and clr outranks accumulation.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= ST_INIT;
      valid_r  <= 1'b0;
      sample_r <= {CNT_W{1'b0}};
      count_r  <= {ACC_W{1'b0}};
      wrap_r   <= 1'b0;
      err_r    <= 1'b0;
`ifdef RIPPLE_SAMPLER_SAT_EN
      sat_r    <= 1'b0;
`endif
    end else begin
      state_r  <= state_nxt_s;
      valid_r  <= valid_nxt_s;
      sample_r <= sample_nxt_s;
      wrap_r   <= wrap_nxt_s;
      count_r  <= bus.clr ? {ACC_W{1'b0}} : count_acc_s;
      err_r    <= bus.clr ? 1'b0 : err_acc_s;
`ifdef RIPPLE_SAMPLER_SAT_EN
      sat_r    <= bus.clr ? 1'b0 : sat_acc_s;
`endif
    end
  end

  assign bus.count_valid = valid_r;
  assign bus.sample_out  = sample_r;
  assign bus.count_out   = count_r;
  assign bus.wrap_pulse  = wrap_r;
  assign bus.step_err    = err_r;
`ifdef RIPPLE_SAMPLER_SAT_EN
  assign bus.acc_sat     = sat_r;
`endif

endmodule

// File: doc/ripple_count_sampler.md
Name: ripple_count_sampler

Overview:
- Downstream consumer of the 3-bit JK ripple up-counter (q1 = LSB, q3 = MSB).
- Brings the asynchronously settling ripple outputs into the system clock domain and filters ripple glitches.
- Accumulates counted steps into a wide synchronous total.
- Reports wrap-around and missed-step errors to control logic.

Parameters:
CNT_W, 3, width of ripple counter input
ACC_W, 12, width of accumulated step total
STABLE_CYC, 2, consecutive equal synchronized samples required to accept a value (>=1)

Ports:
clk  input  1  system clock, all logic on posedge
rst  input  1  synchronous reset, active-high
q_in  input  CNT_W  raw ripple counter outputs, asynchronous to clk, {q3,q2,q1}
en  input  1  1 = accumulate accepted steps; 0 = track baseline only
clr  input  1  synchronous clear of total and error flags
count_valid  output  1  high once the first stable value has been accepted
sample_out  output  CNT_W  last accepted ripple value
count_out  output  ACC_W  accumulated step total
wrap_pulse  output  1  one-cycle pulse when an accepted value wraps past zero
step_err  output  1  sticky: an accepted delta exceeded 1 (missed steps)

Behaviour:
- Reset (rst=1 at posedge): sync flops 0, filter count 0, state INIT.
- Reset output values: count_valid=0, sample_out=0, count_out=0, wrap_pulse=0, step_err=0.
- Reset mid-operation discards any partially filtered value.
- Synchronizer: two flops per bit, giving s2.
- Stability filter:
  - Counter increments while s2 equals the previous s2 and reloads to 1 on any change.
  - The value is "accepted" on the edge where the counter reaches STABLE_CYC.
  - A value is accepted at most once until s2 changes.
- Latency: with q_in settled before edge 1, acceptance and output update occur on edge 2+STABLE_CYC (4 with defaults). Outputs are registered.
- State machine:
  - INIT: on acceptance, sample_out=value, count_valid=1, no accumulation, go to TRACK.
  - TRACK: on acceptance, delta = (value - sample_out) mod 2^CNT_W, computed CNT_W bits wide, then sample_out=value.
    - If en=1: count_out += delta, modulo 2^ACC_W. Delta is zero-extended.
    - If en=0: count_out held; baseline still updated.
    - delta > 1 sets step_err (sticky) regardless of en.
    - value < old sample_out pulses wrap_pulse for exactly one cycle regardless of en.
    - Delta 0 cannot occur in TRACK because acceptance requires a changed value.
- clr=1:
  - count_out=0 and step_err=0 next edge; count_valid, sample_out and state unaffected.
  - clr with simultaneous acceptance: sample_out takes the new value; count_out=0 (clr wins over accumulation); step_err=0; wrap_pulse still fires if the wrap condition holds.
- rst has priority over clr.
- Glitch values shorter than STABLE_CYC cycles in s2 are never accepted.

Optional Feature:
RIPPLE_SAMPLER_SAT_EN
- Defined:
  - count_out saturates at all-ones instead of wrapping.
  - Extra output port acc_sat (1 bit) is added; it is sticky and is set when a saturating add clips.
  - acc_sat is cleared by clr and rst.
- Undefined: count_out wraps modulo 2^ACC_W; acc_sat port absent.

Decomposition:
- Package ripple_sampler_pkg:
  - State enum typedef {INIT, TRACK}.
  - Default parameter constants CNT_W_DEF=3, ACC_W_DEF=12, STABLE_CYC_DEF=2.
  - Function for modular delta.
- Sub-module: sync_filter. Contains the per-bit two-flop synchronizer plus the stability counter. Outputs are the accepted value and a one-cycle accept strobe. Parameters: CNT_W, STABLE_CYC.
- Top level holds the FSM, accumulator and flags.

Test Plan:
- Reset then q_in=3'd5 held → count_valid rises on edge 4 after release; sample_out=5, count_out=0, step_err=0.
- en=1, q_in steps 0→1→…→7→0, each held 6 cycles → count_out=8; wrap_pulse exactly once, on the 7→0 acceptance; step_err=0.
- Baseline 2, jump q_in to 6 held 6 cycles → count_out+=4; step_err=1 and stays 1 until clr.
- q_in=3 baseline, glitch q_in=7 for 1 cycle, back to 3 → no acceptance; count_out and sample_out unchanged.
- en=0, q_in 1→2→3 → sample_out=3, count_out unchanged. Then clr asserted on the same edge as acceptance of 4 → count_out=0, sample_out=4.
- With RIPPLE_SAMPLER_SAT_EN, ACC_W=4, 20 single steps → count_out=15, acc_sat=1. Without the macro, same stimulus → count_out=4.
